// File: rtl/gpio_checkpoint_tx.sv
// GPIO checkpoint transmitter: queues (check, value) pairs and presents them on mprj_io
// with value settled SETUP_CYCLES before the code edge. Optional macro: CKPT_REARM_EN.
module gpio_checkpoint_tx #(
  parameter int DEPTH        = 4,
  parameter int SETUP_CYCLES = 4,
  parameter int HOLD_CYCLES  = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     enable_i,
  input  logic                     flush_i,
  input  logic                     push_valid,
  input  logic [5:0]               push_check,
  input  logic [31:0]              push_value,
  output logic                     push_ready,
  output logic [5:0]               check_o,
  output logic [31:0]              value_o,
  output logic [37:0]              oeb_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef CKPT_REARM_EN
  localparam logic [1:0] S_REARM = 2'd3;
`endif

  logic [37:0]   fifo_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    ckpt_q, ckpt_d;
  logic [5:0]    check_q, check_d;
  logic [31:0]   value_q, value_d;
  logic [37:0]   oeb_q;

  logic          do_push, do_pop;
  logic [5:0]    head_check;
  logic [31:0]   head_value;

  assign push_ready = (level_q < (AW+1)'(DEPTH));
  assign do_push    = push_valid & push_ready & ~flush_i;
  assign do_pop     = (state_q == S_IDLE) & (level_q != '0) & ~flush_i;
  assign {head_check, head_value} = fifo_q[rd_ptr_q];

  assign check_o = check_q;
  assign value_o = value_q;
  assign oeb_o   = oeb_q;
  assign level_o = level_q;
  assign busy_o  = (state_q != S_IDLE) | (level_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Presentation sequencer: value first, code after the setup window, then hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ckpt_d  = ckpt_q;
    check_d = check_q;
    value_d = value_q;
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (level_q != '0) begin
            value_d = head_value;
            ckpt_d  = head_check;
            cnt_d   = CW'(SETUP_CYCLES - 1);
            state_d = S_SETUP;
`ifdef CKPT_REARM_EN
            // A repeated code is dropped to zero first so the monitor still sees an edge.
            if ((head_check == check_q) && (check_q != '0)) begin
              check_d = '0;
              state_d = S_REARM;
            end
`endif
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            check_d = ckpt_q;
            cnt_d   = CW'(HOLD_CYCLES - 1);
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d   = cnt_q - CW'(1);
        end
`ifdef CKPT_REARM_EN
        S_REARM: begin
          if (cnt_q == '0) begin
            cnt_d   = CW'(SETUP_CYCLES - 1);
            state_d = S_SETUP;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ckpt_q   <= '0;
      check_q  <= '0;
      value_q  <= '0;
      oeb_q    <= '1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ckpt_q   <= ckpt_d;
      check_q  <= check_d;
      value_q  <= value_d;
      oeb_q    <= {38{~enable_i}};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (do_push) fifo_q[wr_ptr_q] <= {push_check, push_value};
  end

endmodule

// File: tb/tb_gpio_checkpoint_tx.sv
// Bench for gpio_checkpoint_tx: directed scenarios plus randomized traffic against a
// schedule-based model (pop time + fixed per-entry period). Honors CKPT_REARM_EN.
module tb_gpio_checkpoint_tx;
  localparam int DEPTH = 4;
  localparam int SC    = 4;
  localparam int HC    = 16;
`ifdef CKPT_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, flush, pvalid;
  logic [5:0]  pcheck;
  logic [31:0] pvalue;
  logic        pready, busy_o;
  logic [5:0]  check_o;
  logic [31:0] value_o;
  logic [37:0] oeb_o;
  logic [2:0]  level_o;

  int vectors = 0;
  int miscompares = 0;

  gpio_checkpoint_tx #(.DEPTH(DEPTH), .SETUP_CYCLES(SC), .HOLD_CYCLES(HC)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(enable), .flush_i(flush),
    .push_valid(pvalid), .push_check(pcheck), .push_value(pvalue),
    .push_ready(pready), .check_o(check_o), .value_o(value_o), .oeb_o(oeb_o),
    .busy_o(busy_o), .level_o(level_o)
  );

  // Reference model: each popped entry owns a fixed time slot; the code edge lands
  // a fixed distance after the pop, and the next pop is allowed one period later.
  logic [37:0] mq[$];
  logic [37:0] hd;
  int          e = 0, can_pop = 0, chk_edge = -1;
  logic [5:0]  pend, m_check;
  logic [31:0] m_value;
  logic [37:0] m_oeb;
  int          m_level;
  bit          m_busy, m_ready, acc;

  always @(posedge clk) begin
    e++;
    acc = pvalid && (mq.size() < DEPTH);
    if (rst) begin
      mq.delete(); m_check = '0; m_value = '0; m_oeb = '1; can_pop = 0; chk_edge = -1;
    end else begin
      m_oeb = {38{~enable}};
      if (flush) begin
        mq.delete(); can_pop = e + 1; chk_edge = -1;
      end else begin
        if (e == chk_edge) m_check = pend;
        if (mq.size() != 0 && e >= can_pop) begin
          hd = mq.pop_front();
          m_value = hd[31:0];
          pend = hd[37:32];
          if (REARM && hd[37:32] == m_check && m_check != 6'd0) begin
            m_check = '0; chk_edge = e + 2*SC; can_pop = e + 2*SC + HC + 1;
          end else begin
            chk_edge = e + SC; can_pop = e + SC + HC + 1;
          end
        end
        if (acc) mq.push_back({pcheck, pvalue});
      end
    end
    m_level = mq.size();
    m_ready = (mq.size() < DEPTH);
    m_busy  = (e < can_pop - 1) || (mq.size() != 0);
  end

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; flush = 1'b0; pvalid = 1'b0; pcheck = '0; pvalue = '0;
    repeat (3) @(negedge clk);
    vectors++; if (check_o !== 6'h00) begin miscompares++; $display("FAIL reset_check got=%h exp=00", check_o); end
    vectors++; if (value_o !== 32'h0) begin miscompares++; $display("FAIL reset_value got=%h exp=0", value_o); end
    vectors++; if (oeb_o !== '1) begin miscompares++; $display("FAIL reset_oeb got=%h exp=3fffffffff", oeb_o); end
    vectors++; if (pready !== 1'b1 || busy_o !== 1'b0 || level_o !== 3'd0) begin
      miscompares++; $display("FAIL reset_ctrl got rdy=%b busy=%b lvl=%0d exp 1/0/0", pready, busy_o, level_o);
    end
    rst = 1'b0; enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [5:0] prev_c, exp_c;
    logic [31:0] prev_v;
    pvalid = 1'b1; pcheck = 6'h0a; pvalue = 32'hdcba7cfb;
    @(negedge clk); pvalid = 1'b0;
    vectors++; if (level_o !== 3'd1 || value_o !== 32'h0) begin
      miscompares++; $display("FAIL single_push got lvl=%0d val=%h exp 1/0", level_o, value_o);
    end
    prev_c = check_o; prev_v = value_o;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      exp_c = (k >= 1 + SC) ? 6'h0a : 6'h00;
      vectors++; if (value_o !== 32'hdcba7cfb || check_o !== exp_c) begin
        miscompares++; $display("FAIL single_k%0d got chk=%h val=%h exp chk=%h val=dcba7cfb", k, check_o, value_o, exp_c);
      end
      vectors++; if (check_o !== prev_c && value_o !== prev_v) begin
        miscompares++; $display("FAIL single_order_k%0d got both changed chk=%h val=%h exp value settled first", k, check_o, value_o);
      end
      vectors++; if (busy_o !== ((k < 1 + SC + HC) ? 1'b1 : 1'b0)) begin
        miscompares++; $display("FAIL single_busy_k%0d got=%b exp=%b", k, busy_o, (k < 1 + SC + HC));
      end
      prev_c = check_o; prev_v = value_o;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  codes [5];
    logic [31:0] vals  [5];
    logic [5:0]  prev_c;
    int idx = 0, seen = 0, t = 0, last_t = 0;
    bit accept, full_seen = 0;
    codes = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05};
    vals  = '{32'h19, 32'h0f, 32'h0f, 32'h12bc, 32'h005d};
    prev_c = check_o;
    while (t < 200 && seen < 5) begin
      if (idx < 5) begin pvalid = 1'b1; pcheck = codes[idx]; pvalue = vals[idx]; end
      else pvalid = 1'b0;
      accept = pvalid && pready;
      @(negedge clk); t++;
      if (accept) idx++;
      if (pready === 1'b0) full_seen = 1;
      vectors++;
      if ({check_o, value_o, oeb_o, pready, busy_o, level_o} !== {m_check, m_value, m_oeb, m_ready, m_busy, 3'(m_level)}) begin
        miscompares++;
        $display("FAIL b2b_model t=%0d got chk=%h val=%h oeb=%h rdy=%b busy=%b lvl=%0d exp chk=%h val=%h oeb=%h rdy=%b busy=%b lvl=%0d",
                 t, check_o, value_o, oeb_o, pready, busy_o, level_o, m_check, m_value, m_oeb, m_ready, m_busy, m_level);
      end
      if (check_o !== prev_c) begin
        vectors++; if (check_o !== codes[seen] || value_o !== vals[seen]) begin
          miscompares++; $display("FAIL b2b_pair%0d got chk=%h val=%h exp chk=%h val=%h", seen, check_o, value_o, codes[seen], vals[seen]);
        end
        if (seen > 0) begin
          vectors++; if (t - last_t != SC + HC + 1) begin
            miscompares++; $display("FAIL b2b_period%0d got=%0d exp=%0d", seen, t - last_t, SC + HC + 1);
          end
        end
        last_t = t; seen++; prev_c = check_o;
      end
    end
    pvalid = 1'b0;
    vectors++; if (seen != 5) begin miscompares++; $display("FAIL b2b_timeout got=%0d pairs exp=5", seen); end
    vectors++; if (!full_seen) begin miscompares++; $display("FAIL b2b_full got push_ready never low exp low when full"); end
  endtask

  task automatic test_flush();
    int t = 0;
    pvalid = 1'b1; pcheck = 6'h06; pvalue = 32'h0259;
    @(negedge clk); pvalid = 1'b0;
    while (check_o !== 6'h06 && t < 200) begin @(negedge clk); t++; end
    vectors++; if (t >= 200) begin miscompares++; $display("FAIL flush_wait got chk=%h exp=06", check_o); end
    pvalid = 1'b1; pcheck = 6'h2a; pvalue = 32'h1111;
    @(negedge clk); pcheck = 6'h2b; pvalue = 32'h2222;
    @(negedge clk);
    vectors++; if (level_o !== 3'd2) begin miscompares++; $display("FAIL flush_queued got=%0d exp=2", level_o); end
    flush = 1'b1; pcheck = 6'h2c; pvalue = 32'h3333;
    @(negedge clk); flush = 1'b0; pvalid = 1'b0;
    vectors++; if (level_o !== 3'd0 || busy_o !== 1'b0 || pready !== 1'b1) begin
      miscompares++; $display("FAIL flush_ctrl got lvl=%0d busy=%b rdy=%b exp 0/0/1", level_o, busy_o, pready);
    end
    vectors++; if (check_o !== 6'h06 || value_o !== 32'h0259) begin
      miscompares++; $display("FAIL flush_retain got chk=%h val=%h exp 06/00000259", check_o, value_o);
    end
    repeat (3) @(negedge clk);
    vectors++; if (level_o !== 3'd0 || check_o !== 6'h06 || value_o !== 32'h0259) begin
      miscompares++; $display("FAIL flush_after got lvl=%0d chk=%h val=%h exp 0/06/00000259", level_o, check_o, value_o);
    end
  endtask

  task automatic test_reset_mid();
    pvalid = 1'b1; pcheck = 6'h11; pvalue = 32'h1234;
    @(negedge clk); pvalid = 1'b0;
    @(negedge clk);
    vectors++; if (value_o !== 32'h1234 || check_o !== 6'h06 || busy_o !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_setup got val=%h chk=%h busy=%b exp 00001234/06/1", value_o, check_o, busy_o);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    vectors++; if ({check_o, value_o, oeb_o, pready, busy_o, level_o} !== {6'h0, 32'h0, 38'h3fffffffff, 1'b1, 1'b0, 3'd0}) begin
      miscompares++; $display("FAIL rstmid_vals got chk=%h val=%h oeb=%h rdy=%b busy=%b lvl=%0d exp reset values", check_o, value_o, oeb_o, pready, busy_o, level_o);
    end
    @(negedge clk);
    vectors++; if (oeb_o !== 38'h0) begin miscompares++; $display("FAIL rstmid_oeb got=%h exp=0", oeb_o); end
  endtask

  task automatic test_repeat_code();
    logic [5:0] hist[$];
    int         hist_t[$];
    logic [5:0] prev_c;
    int         val_t = -1;
    pvalid = 1'b1; pcheck = 6'h07; pvalue = 32'h8;
    @(negedge clk); pvalue = 32'ha;
    @(negedge clk); pvalid = 1'b0;
    prev_c = check_o;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (check_o !== prev_c) begin hist.push_back(check_o); hist_t.push_back(t); prev_c = check_o; end
      if (value_o === 32'ha && val_t < 0) val_t = t;
    end
    vectors++; if (value_o !== 32'ha) begin miscompares++; $display("FAIL repeat_value got=%h exp=0000000a", value_o); end
    if (REARM) begin
      vectors++;
      if (hist.size() != 3 || hist[0] !== 6'h07 || hist[1] !== 6'h00 || hist[2] !== 6'h07) begin
        miscompares++; $display("FAIL repeat_rearm_seq got %0d edges exp 07,00,07", hist.size());
      end else begin
        vectors++; if (hist_t[2] - val_t != 2*SC) begin
          miscompares++; $display("FAIL repeat_rearm_setup got=%0d exp=%0d", hist_t[2] - val_t, 2*SC);
        end
      end
    end else begin
      vectors++;
      if (hist.size() != 1 || hist[0] !== 6'h07 || check_o !== 6'h07) begin
        miscompares++; $display("FAIL repeat_norearm_seq got %0d edges chk=%h exp one edge to 07", hist.size(), check_o);
      end
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    @(negedge clk);
    vectors++; if (oeb_o !== '1) begin miscompares++; $display("FAIL enable_off got=%h exp all ones", oeb_o); end
    enable = 1'b1;
    #1;
    vectors++; if (oeb_o !== '1) begin miscompares++; $display("FAIL enable_latency got=%h exp all ones", oeb_o); end
    @(negedge clk);
    vectors++; if (oeb_o !== 38'h0) begin miscompares++; $display("FAIL enable_on got=%h exp=0", oeb_o); end
    enable = 1'b0;
    @(negedge clk);
    vectors++; if (oeb_o !== '1) begin miscompares++; $display("FAIL enable_off2 got=%h exp all ones", oeb_o); end
    enable = 1'b1;
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      pvalid = ($urandom % 3) != 0;
      pcheck = 6'($urandom_range(0, 3));
      pvalue = $urandom;
      flush  = ($urandom % 60) == 0;
      enable = ($urandom % 8) != 0;
      rst    = ($urandom % 250) == 0;
      @(negedge clk);
      vectors++;
      if ({check_o, value_o, oeb_o, pready, busy_o, level_o} !== {m_check, m_value, m_oeb, m_ready, m_busy, 3'(m_level)}) begin
        miscompares++;
        $display("FAIL random_model t=%0d got chk=%h val=%h oeb=%h rdy=%b busy=%b lvl=%0d exp chk=%h val=%h oeb=%h rdy=%b busy=%b lvl=%0d",
                 t, check_o, value_o, oeb_o, pready, busy_o, level_o, m_check, m_value, m_oeb, m_ready, m_busy, m_level);
      end
    end
    pvalid = 1'b0; flush = 1'b0; rst = 1'b0; enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_repeat_code();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
